// File: rtl/page_table_walker.sv
`default_nettype none
// ============================================================================
// Module   : page_table_walker
// Purpose  : Two-level (Sv32-style) hardware page-table walker. Accepts one
//            walk request from the TLB, issues up to two PTE reads, and
//            returns the leaf PTE (all-zero on any fault or timeout).
// Options  : PTW_PERF_CNT_EN -- adds walk_cnt_o / fault_cnt_o counters.
// Revision : 1.0 - initial release
// ============================================================================
module page_table_walker #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst,               // asynchronous, active-low
  input  logic [19:0] satp_ppn_i,
  input  logic        ptw_req_valid_i,
  output logic        ptw_req_ready_o,
  input  logic [31:0] ptw_vaddr_i,
  output logic        ptw_resp_valid_o,
  input  logic        ptw_resp_ready_i,
  output logic [31:0] ptw_pte_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_valid_i,
  output logic        mem_resp_ready_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
`ifdef PTW_PERF_CNT_EN
  ,
  output logic [31:0] walk_cnt_o,
  output logic [31:0] fault_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_WAIT = 3'd2,
    L2_REQ  = 3'd3,
    L2_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  // Last value the wait counter holds before a timeout is declared, so a
  // WAIT state lasts at most TIMEOUT_CYCLES cycles.
  localparam logic [TIMEOUT_BITS-1:0] c_TMO_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [9:0]              r_vpn0;
  logic [TIMEOUT_BITS-1:0] r_tmo_cnt;
  logic [31:0]             w_addr_nxt;
  logic [31:0]             w_pte_nxt;
  logic                    w_accept;
  logic                    w_rsp_fire;
  logic                    w_timeout;
  logic                    w_unused;

  assign w_accept   = ptw_req_valid_i && ptw_req_ready_o;
  assign w_rsp_fire = mem_resp_valid_i && mem_resp_ready_o;
  assign w_timeout  = (r_tmo_cnt == c_TMO_LAST);

  // Page-offset bits and PTE software/A/D/U/G bits play no part in the walk.
  assign w_unused = &{1'b0, ptw_vaddr_i[11:0], mem_rdata_i[11:3]};

  // Next-state, next-address and next-PTE decode; every output is registered
  // from these values so nothing is combinational from the inputs.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = mem_addr_o;
    w_pte_nxt   = ptw_pte_o;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = L1_REQ;
          w_addr_nxt  = {satp_ppn_i, ptw_vaddr_i[31:22], 2'b00};
        end
      end
      L1_REQ: begin
        if (mem_req_ready_i) w_state_nxt = L1_WAIT;
      end
      L1_WAIT: begin
        if (w_rsp_fire) begin
          if (mem_err_i || !mem_rdata_i[2]) begin
            w_pte_nxt   = 32'h0;
            w_state_nxt = RESP;
          end else if (mem_rdata_i[1:0] == 2'b00) begin
            w_state_nxt = L2_REQ;
            w_addr_nxt  = {mem_rdata_i[31:12], r_vpn0, 2'b00};
          end else begin
            // Superpage leaf: a non-zero PPN[0] field means misaligned.
            w_state_nxt = RESP;
            w_pte_nxt   = (mem_rdata_i[21:12] == 10'd0) ?
                          {mem_rdata_i[31:22], r_vpn0, 9'd0, mem_rdata_i[2:0]} : 32'h0;
          end
        end else if (w_timeout) begin
          w_pte_nxt   = 32'h0;
          w_state_nxt = RESP;
        end
      end
      L2_REQ: begin
        if (mem_req_ready_i) w_state_nxt = L2_WAIT;
      end
      L2_WAIT: begin
        if (w_rsp_fire) begin
          w_state_nxt = RESP;
          if (mem_err_i || !mem_rdata_i[2] || (mem_rdata_i[1:0] == 2'b00)) begin
            w_pte_nxt = 32'h0;
          end else begin
            w_pte_nxt = {mem_rdata_i[31:12], 9'd0, mem_rdata_i[2:0]};
          end
        end else if (w_timeout) begin
          w_pte_nxt   = 32'h0;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (ptw_resp_ready_i) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Walk context: VPN[0] captured on acceptance, wait counter restarts at
  // zero every time a WAIT state is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vpn0    <= 10'd0;
      r_tmo_cnt <= '0;
    end else begin
      if ((r_state == IDLE) && w_accept) r_vpn0 <= ptw_vaddr_i[21:12];
      if ((r_state == L1_WAIT) || (r_state == L2_WAIT)) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      else                                              r_tmo_cnt <= '0;
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptw_req_ready_o  <= 1'b0;
      ptw_resp_valid_o <= 1'b0;
      ptw_pte_o        <= 32'h0;
      mem_req_valid_o  <= 1'b0;
      mem_addr_o       <= 32'h0;
      mem_resp_ready_o <= 1'b0;
    end else begin
      ptw_req_ready_o  <= (w_state_nxt == IDLE);
      ptw_resp_valid_o <= (w_state_nxt == RESP);
      ptw_pte_o        <= w_pte_nxt;
      mem_req_valid_o  <= (w_state_nxt == L1_REQ) || (w_state_nxt == L2_REQ);
      mem_addr_o       <= w_addr_nxt;
      // Also ready in IDLE/RESP so stray late responses are drained.
      mem_resp_ready_o <= (w_state_nxt == IDLE) || (w_state_nxt == L1_WAIT) ||
                          (w_state_nxt == L2_WAIT) || (w_state_nxt == RESP);
    end
  end

`ifdef PTW_PERF_CNT_EN
  // Walk and fault counters, advanced on each response handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      walk_cnt_o  <= 32'h0;
      fault_cnt_o <= 32'h0;
    end else if (ptw_resp_valid_o && ptw_resp_ready_i) begin
      walk_cnt_o <= walk_cnt_o + 32'd1;
      if (ptw_pte_o == 32'h0) fault_cnt_o <= fault_cnt_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_page_table_walker.sv
`default_nettype none
// ============================================================================
// Module   : tb_page_table_walker
// Purpose  : Self-checking bench for page_table_walker: directed walks,
//            handshake stalls, timeout, reset mid-walk and random walks
//            against a behavioural walk model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_page_table_walker;

  localparam int c_TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] satp_ppn_i = 20'h0;
  logic        ptw_req_valid_i = 1'b0;
  logic        ptw_req_ready_o;
  logic [31:0] ptw_vaddr_i = 32'h0;
  logic        ptw_resp_valid_o;
  logic        ptw_resp_ready_i = 1'b0;
  logic [31:0] ptw_pte_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_resp_valid_i;
  logic        mem_resp_ready_o;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
`ifdef PTW_PERF_CNT_EN
  logic [31:0] walk_cnt_o;
  logic [31:0] fault_cnt_o;
`endif

  page_table_walker #(.TIMEOUT_CYCLES(c_TMO), .TIMEOUT_BITS(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .satp_ppn_i       (satp_ppn_i),
    .ptw_req_valid_i  (ptw_req_valid_i),
    .ptw_req_ready_o  (ptw_req_ready_o),
    .ptw_vaddr_i      (ptw_vaddr_i),
    .ptw_resp_valid_o (ptw_resp_valid_o),
    .ptw_resp_ready_i (ptw_resp_ready_i),
    .ptw_pte_o        (ptw_pte_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .mem_rdata_i      (mem_rdata_i),
    .mem_err_i        (mem_err_i)
`ifdef PTW_PERF_CNT_EN
    ,
    .walk_cnt_o       (walk_cnt_o),
    .fault_cnt_o      (fault_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_walks  = 0;
  int exp_faults = 0;

  // Sparse memory image and per-address bus-error flags.
  logic [31:0] mem_data [logic [31:0]];
  bit          mem_err  [logic [31:0]];
  logic [31:0] acc_q [$];

  // Memory responder controls.
  bit silent  = 1'b0;
  bit zw      = 1'b0;
  bit stray   = 1'b0;
  int stall_n = 0;
  int fixdly  = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_data.exists(a) ? mem_data[a] : 32'h0;
  endfunction

  function automatic bit er(input logic [31:0] a);
    return mem_err.exists(a) ? mem_err[a] : 1'b0;
  endfunction

  // Behavioural walk: which addresses get read, and what PTE comes back.
  function automatic logic [31:0] ref_walk(input logic [19:0] satp, input logic [31:0] va,
                                           output int nacc, output logic [31:0] a0,
                                           output logic [31:0] a1);
    logic [31:0] p, q;
    a0   = 32'(satp) * 32'd4096 + (va >> 22) * 32'd4;
    a1   = 32'h0;
    nacc = 1;
    p    = rd(a0);
    if (er(a0) || (p % 8) < 4) return 32'h0;
    if ((p % 4) != 0) begin
      if (((p >> 12) % 1024) != 0) return 32'h0;
      return (p >> 22) * 32'h40_0000 + ((va >> 12) % 1024) * 32'd4096 + (p % 8);
    end
    nacc = 2;
    a1   = (p >> 12) * 32'd4096 + ((va >> 12) % 1024) * 32'd4;
    q    = rd(a1);
    if (er(a1) || (q % 8) < 4 || (q % 4) == 0) return 32'h0;
    return (q >> 12) * 32'd4096 + (q % 8);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Memory model: logs accepted request addresses, answers after a delay,
  // applies request-side stalls and checks request stability while stalled.
  initial begin
    bit          req_hs, rsp_hs, prev_stall, pend;
    logic [31:0] prev_addr, paddr;
    int          dly;
    prev_stall = 1'b0; pend = 1'b0; prev_addr = 32'h0; paddr = 32'h0; dly = 0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0;
    forever begin
      @(negedge clk);
      req_hs = rst && mem_req_valid_o && mem_req_ready_i;
      rsp_hs = rst && mem_resp_valid_i && mem_resp_ready_o;
      if (prev_stall && rst) begin
        chk("mreq_hold_valid", 32'(mem_req_valid_o), 32'd1);
        chk("mreq_hold_addr", mem_addr_o, prev_addr);
      end
      prev_stall = rst && mem_req_valid_o && !mem_req_ready_i;
      prev_addr  = mem_addr_o;
      if (req_hs) begin
        acc_q.push_back(mem_addr_o);
        if (!silent) begin
          pend  = 1'b1;
          paddr = mem_addr_o;
          dly   = (fixdly >= 0) ? fixdly : (zw ? 0 : int'($urandom_range(0, 2)));
        end
      end
      @(posedge clk);
      #1;
      if (rsp_hs) begin
        mem_resp_valid_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0;
      end
      if (stray && !mem_resp_valid_i) begin
        mem_resp_valid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; mem_err_i = 1'b0;
        stray = 1'b0;
      end else if (pend && !mem_resp_valid_i) begin
        if (dly == 0) begin
          mem_resp_valid_i = 1'b1; mem_rdata_i = rd(paddr); mem_err_i = er(paddr);
          pend = 1'b0;
        end else begin
          dly--;
        end
      end
      if (mem_req_valid_o && stall_n > 0) begin
        mem_req_ready_i = 1'b0;
        stall_n--;
      end else begin
        mem_req_ready_i = zw ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
    end
  end

  // One complete walk: request, wait for response, hold ready low for
  // 'hold' cycles, then check the PTE and the memory addresses used.
  task automatic run_walk(input logic [19:0] satp, input logic [31:0] va, input int hold,
                          input int exp_lat, input bit tmo, output logic [31:0] got);
    logic [31:0] exp, a0, a1;
    int          nacc, c_acc, c_rsp;
    bit          ok;
    exp = ref_walk(satp, va, nacc, a0, a1);
    if (tmo) begin exp = 32'h0; nacc = 1; end
    got = 32'hFFFF_FFFF; c_acc = 0; c_rsp = 0;
    acc_q.delete();
    @(posedge clk);
    #1;
    ptw_req_valid_i = 1'b1; satp_ppn_i = satp; ptw_vaddr_i = va;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ptw_req_ready_o) begin ok = 1'b1; c_acc = cyc; end
    end
    chk("req_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    ptw_req_valid_i = 1'b0; satp_ppn_i = 20'($urandom); ptw_vaddr_i = $urandom;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ptw_resp_valid_o) begin ok = 1'b1; c_rsp = cyc; end
    end
    chk("resp_valid", 32'(ok), 32'd1);
    if (ok) begin
      if (exp_lat >= 0) chk("latency", 32'(c_rsp - c_acc), 32'(exp_lat));
      for (int i = 0; i < hold; i++) begin
        chk("resp_hold_valid", 32'(ptw_resp_valid_o), 32'd1);
        chk("resp_hold_pte", ptw_pte_o, exp);
        @(negedge clk);
      end
      got = ptw_pte_o;
      chk("pte", ptw_pte_o, exp);
      ptw_resp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      ptw_resp_ready_i = 1'b0;
      exp_walks++;
      if (exp == 32'h0) exp_faults++;
      @(negedge clk);
      chk("resp_drop", 32'(ptw_resp_valid_o), 32'd0);
    end
    chk("n_access", 32'(acc_q.size()), 32'(nacc));
    if (acc_q.size() > 0) chk("addr_l1", acc_q[0], a0);
    if (nacc == 2 && acc_q.size() > 1) chk("addr_l2", acc_q[1], a1);
  endtask

  task automatic clear_mem();
    mem_data.delete();
    mem_err.delete();
  endtask

  task automatic rand_walk();
    logic [19:0] satp, ppn, ppn2;
    logic [31:0] va, a0, a1, l1, l2, got;
    logic [8:0]  noise;
    logic [1:0]  rw;
    int          k, j;
    satp = 20'($urandom); va = $urandom; ppn = 20'($urandom); ppn2 = 20'($urandom);
    noise = 9'($urandom); rw = 2'($urandom_range(1, 3));
    clear_mem();
    a0 = 32'(satp) * 32'd4096 + (va >> 22) * 32'd4;
    k  = int'($urandom_range(0, 5));
    case (k)
      0:       l1 = {ppn, noise, 1'b0, 2'($urandom)};
      2:       l1 = {ppn[19:10], 10'd0, noise, 1'b1, rw};
      3:       l1 = {ppn[19:10], ppn[9:0] | 10'd1, noise, 1'b1, rw};
      default: l1 = {ppn, noise, 3'b100};
    endcase
    mem_data[a0] = l1;
    if (k == 4) mem_err[a0] = 1'b1;
    if (k == 1 || k == 5) begin
      a1 = 32'(ppn) * 32'd4096 + ((va >> 12) % 1024) * 32'd4;
      j  = int'($urandom_range(0, 4));
      case (j)
        2:       l2 = {ppn2, noise, 1'b0, 2'($urandom)};
        3:       l2 = {ppn2, noise, 3'b100};
        default: l2 = {ppn2, noise, 1'b1, rw};
      endcase
      mem_data[a1] = l2;
      if (j == 4) mem_err[a1] = 1'b1;
    end
    zw = ($urandom_range(0, 3) == 0);
    run_walk(satp, va, int'($urandom_range(0, 3)), -1, 1'b0, got);
  endtask

  task automatic setup_035();
    clear_mem();
    mem_data[32'h0001_0004] = 32'h0002_0004;
    mem_data[32'h0002_000C] = 32'h0ABC_D007;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    bit          ok;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_ctrl", 32'({ptw_req_ready_o, ptw_resp_valid_o, mem_req_valid_o, mem_resp_ready_o}), 32'd0);
    chk("rst_pte", ptw_pte_o, 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rel_ready_low", 32'(ptw_req_ready_o), 32'd0);
    @(posedge clk);
    #1 chk("rel_ready_high", 32'(ptw_req_ready_o), 32'd1);

    // Two-level walk with zero-wait memory.
    zw = 1'b1;
    setup_035();
    run_walk(20'h00010, 32'h0040_3123, 0, 5, 1'b0, got);
    chk("two_level_pte", got, 32'h0ABC_D007);
    if (acc_q.size() == 2) begin
      chk("two_level_a0", acc_q[0], 32'h0001_0004);
      chk("two_level_a1", acc_q[1], 32'h0002_000C);
    end

    // Superpage: invalid leaf, then a valid aligned leaf.
    clear_mem();
    mem_data[32'h0001_0004] = 32'h0080_0003;
    run_walk(20'h00010, 32'h0040_3123, 0, 3, 1'b0, got);
    chk("super_inval", got, 32'h0);
    mem_data[32'h0001_0004] = 32'h0080_0007;
    run_walk(20'h00010, 32'h0040_3123, 0, 3, 1'b0, got);
    chk("super_leaf", got, 32'h0080_3007);

    // Bus error on the second-level read.
    setup_035();
    mem_err[32'h0002_000C] = 1'b1;
    run_walk(20'h00010, 32'h0040_3123, 1, 5, 1'b0, got);
    chk("l2_err_pte", got, 32'h0);

    // Request stall of 3 cycles and response backpressure of 5 cycles.
    setup_035();
    stall_n = 3;
    run_walk(20'h00010, 32'h0040_3123, 5, -1, 1'b0, got);
    chk("stall_pte", got, 32'h0ABC_D007);

    // Memory never answers: accept, handshake cycle, then c_TMO wait cycles.
    silent = 1'b1;
    run_walk(20'h00010, 32'h0040_3123, 0, c_TMO + 2, 1'b1, got);
    chk("timeout_pte", got, 32'h0);
    silent = 1'b0;
    stray  = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stray_drained", 32'(mem_resp_valid_i), 32'd0);
    chk("stray_idle", 32'(ptw_req_ready_o), 32'd1);
    run_walk(20'h00010, 32'h0040_3123, 0, 5, 1'b0, got);
    chk("after_stray_pte", got, 32'h0ABC_D007);

    // Reset while waiting on the second-level read.
    fixdly = 2;
    acc_q.delete();
    @(posedge clk);
    #1;
    ptw_req_valid_i = 1'b1; satp_ppn_i = 20'h00010; ptw_vaddr_i = 32'h0040_3123;
    @(posedge clk);
    #1;
    ptw_req_valid_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (acc_q.size() == 2) ok = 1'b1;
    end
    chk("reach_l2", 32'(ok), 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_ctrl", 32'({ptw_req_ready_o, ptw_resp_valid_o, mem_req_valid_o, mem_resp_ready_o}), 32'd0);
    chk("midrst_pte", ptw_pte_o, 32'h0);
    chk("midrst_addr", mem_addr_o, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    fixdly = -1;
    exp_walks = 0; exp_faults = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_resp", 32'(ptw_resp_valid_o), 32'd0);
    run_walk(20'h00010, 32'h0040_3123, 0, 5, 1'b0, got);
    chk("post_rst_pte", got, 32'h0ABC_D007);

    // Random walks against the model.
    for (int n = 0; n < 150; n++) rand_walk();

`ifdef PTW_PERF_CNT_EN
    chk("walk_cnt", walk_cnt_o, 32'(exp_walks));
    chk("fault_cnt", fault_cnt_o, 32'(exp_faults));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
